// File: rtl/turn_ctrl.sv
// Two-player turn controller: edge-detects start/go commits, latches moves, counts rounds.
// Optional forced hand-over on idle turns when TURN_TIMEOUT_EN is defined.
module turn_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] p1_btn,
  input  logic       p1_go,
  input  logic [1:0] p2_btn,
  input  logic       p2_go,
  output logic [1:0] in1,
  output logic [1:0] in2,
  output logic       enable,
  output logic       move_valid,
  output logic       timeout,
  output logic [7:0] round,
  output logic       busy,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_P1   = 2'd1,
    S_P2   = 2'd2
  } state_t;

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("turn_ctrl: TIMEOUT_CYC out of range 2..65535");
  end

  state_t r_state;
  state_t w_state_nxt;

  logic r_start_q;
  logic r_p1_q;
  logic r_p2_q;
  logic r_arm;
  logic w_start_edge;
  logic w_p1_edge;
  logic w_p2_edge;
  logic w_accept1;
  logic w_accept2;
  logic w_force;
  logic w_start_game;
  logic w_timeout_hit;

  // r_arm blocks the first cycle after reset, so a level held across release is not an edge.
  assign w_start_edge = start & ~r_start_q & r_arm;
  assign w_p1_edge    = p1_go & ~r_p1_q & r_arm;
  assign w_p2_edge    = p2_go & ~r_p2_q & r_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start_q <= 1'b0;
      r_p1_q    <= 1'b0;
      r_p2_q    <= 1'b0;
      r_arm     <= 1'b0;
    end else begin
      r_start_q <= start;
      r_p1_q    <= p1_go;
      r_p2_q    <= p2_go;
      r_arm     <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_accept1    = 1'b0;
    w_accept2    = 1'b0;
    w_force      = 1'b0;
    w_start_game = 1'b0;
    if (stop) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            w_state_nxt  = S_P1;
            w_start_game = 1'b1;
          end
        end
        S_P1: begin
          if (w_p1_edge) begin
            w_accept1   = 1'b1;
            w_state_nxt = S_P2;
          end else if (w_timeout_hit) begin
            w_accept1   = 1'b1;
            w_force     = 1'b1;
            w_state_nxt = S_P2;
          end
        end
        S_P2: begin
          if (w_p2_edge) begin
            w_accept2   = 1'b1;
            w_state_nxt = S_P1;
          end else if (w_timeout_hit) begin
            w_accept2   = 1'b1;
            w_force     = 1'b1;
            w_state_nxt = S_P1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      in1        <= 2'b00;
      in2        <= 2'b00;
      enable     <= 1'b0;
      move_valid <= 1'b0;
      round      <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      move_valid <= w_accept1 | w_accept2;
      if (w_start_game) begin
        round  <= 8'd0;
        enable <= 1'b0;
      end
      if (w_accept1) begin
        in1    <= w_force ? 2'b00 : p1_btn;
        enable <= 1'b0;
      end
      if (w_accept2) begin
        in2    <= w_force ? 2'b00 : p2_btn;
        enable <= 1'b1;
        round  <= round + 8'd1;
      end
    end
  end

`ifdef TURN_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_turn_cnt;
  logic        r_timeout;

  assign w_timeout_hit = (r_turn_cnt == TO_LAST);
  assign timeout       = r_timeout;

  // Counter restarts on every state entry so each turn gets the full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_turn_cnt <= 16'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_timeout <= w_force;
      if (r_state == S_IDLE || w_state_nxt != r_state) begin
        r_turn_cnt <= 16'd0;
      end else begin
        r_turn_cnt <= r_turn_cnt + 16'd1;
      end
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign timeout       = 1'b0;
`endif

  assign busy    = (r_state != S_IDLE);
  assign o_state = r_state;

endmodule

// File: tb/tb_turn_ctrl.sv
// Bench for turn_ctrl: directed scenarios plus random play checked against a game-level model.
module tb_turn_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, p1_go, p2_go;
  logic [1:0] p1_btn, p2_btn;
  logic [1:0] in1, in2, o_state;
  logic       enable, move_valid, timeout, busy;
  logic [7:0] round;

  turn_ctrl #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .p1_btn(p1_btn), .p1_go(p1_go), .p2_btn(p2_btn), .p2_go(p2_go),
    .in1(in1), .in2(in2), .enable(enable), .move_valid(move_valid),
    .timeout(timeout), .round(round), .busy(busy), .o_state(o_state)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Game-level reference: who plays, last moves, rounds played, pulses due this cycle.
  bit playing;
  int turn;
  int m_in1, m_in2, m_en, m_round, m_mv, m_to, m_cnt;
  bit prev_s, prev_g1, prev_g2, fresh;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("in1", in1, m_in1);
    check("in2", in2, m_in2);
    check("enable", enable, m_en);
    check("move_valid", move_valid, m_mv);
    check("timeout", timeout, m_to);
    check("round", round, m_round);
    check("busy", busy, playing);
    check("state", o_state, playing ? turn : 0);
  endtask

  task automatic model_reset();
    playing = 0; turn = 1;
    m_in1 = 0; m_in2 = 0; m_en = 0; m_round = 0; m_mv = 0; m_to = 0; m_cnt = 0;
    prev_s = 0; prev_g1 = 0; prev_g2 = 0; fresh = 1;
  endtask

  task automatic model_step(input bit s, input bit st, input int b1, input bit g1,
                            input int b2, input bit g2);
    bit se, e1, e2, took, forced;
    se = s && !prev_s && !fresh;
    e1 = g1 && !prev_g1 && !fresh;
    e2 = g2 && !prev_g2 && !fresh;
    m_mv = 0; m_to = 0;
    if (st) begin
      playing = 0;
    end else if (!playing) begin
      if (se) begin
        playing = 1; turn = 1; m_round = 0; m_en = 0; m_cnt = 0;
      end
    end else begin
      took   = (turn == 1) ? e1 : e2;
      forced = 0;
`ifdef TURN_TIMEOUT_EN
      forced = !took && (m_cnt == TO - 1);
`endif
      if (took || forced) begin
        m_mv = 1; m_to = forced ? 1 : 0; m_cnt = 0;
        if (turn == 1) begin
          m_in1 = forced ? 0 : b1; m_en = 0; turn = 2;
        end else begin
          m_in2 = forced ? 0 : b2; m_en = 1; turn = 1;
          m_round = (m_round + 1) % 256;
        end
      end else begin
        m_cnt++;
      end
    end
    prev_s = s; prev_g1 = g1; prev_g2 = g2; fresh = 0;
  endtask

  task automatic step(input bit s, input bit st, input logic [1:0] b1, input bit g1,
                      input logic [1:0] b2, input bit g2);
    start = s; stop = st; p1_btn = b1; p1_go = g1; p2_btn = b2; p2_go = g2;
    model_step(s, st, int'(b1), g1, int'(b2), g2);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 2'b00, 0, 2'b00, 0);
  endtask

  // Reset lands between edges; outputs must clear without waiting for a clock.
  task automatic do_reset(input bit hold_start);
    #2;
    rst_n = 1'b0;
    start = hold_start; stop = 0; p1_go = 0; p2_go = 0;
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    start = 0; stop = 0; p1_go = 0; p2_go = 0; p1_btn = 0; p2_btn = 0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_outputs();
    #11 rst_n = 1'b1;

    idle(2);
    step(1, 0, 2'b00, 0, 2'b00, 0);
    check("start_busy", busy, 1);
    idle(1);

    // First P1 move
    step(0, 0, 2'b10, 1, 2'b00, 0);
    check("p1_in1", in1, 2'b10);
    check("p1_mv", move_valid, 1);
    check("p1_state", o_state, 2);
    step(0, 0, 2'b10, 0, 2'b00, 0);

    // First P2 move completes round 1
    step(0, 0, 2'b00, 0, 2'b11, 1);
    check("p2_in2", in2, 2'b11);
    check("p2_en", enable, 1);
    check("p2_round", round, 1);
    step(0, 0, 2'b00, 0, 2'b11, 0);

    // Wrong-player edge, then simultaneous edges
    step(0, 0, 2'b00, 0, 2'b01, 1);
    step(0, 0, 2'b00, 0, 2'b01, 0);
    step(0, 0, 2'b01, 1, 2'b10, 1);
    check("simul_in1", in1, 2'b01);
    check("simul_in2", in2, 2'b11);
    step(0, 0, 2'b01, 0, 2'b10, 0);

    // Stop against a P2 commit in the same cycle
    step(0, 1, 2'b00, 0, 2'b10, 1);
    check("stop_busy", busy, 0);
    check("stop_mv", move_valid, 0);
    check("stop_in2", in2, 2'b11);
    step(0, 0, 2'b00, 0, 2'b00, 0);

    // 256 full rounds wrap the counter
    step(1, 0, 2'b00, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 2'b00, 0);
    for (int r = 0; r < 256; r++) begin
      step(0, 0, 2'(r), 1, 2'b00, 0);
      step(0, 0, 2'b00, 0, 2'b00, 0);
      step(0, 0, 2'b00, 0, 2'(r + 1), 1);
      step(0, 0, 2'b00, 0, 2'b00, 0);
    end
    check("round_wrap", round, 0);

    // Fresh game, then leave P1 idle
    step(0, 1, 2'b00, 0, 2'b00, 0);
    step(0, 0, 2'b00, 0, 2'b00, 0);
    step(1, 0, 2'b00, 0, 2'b00, 0);
    idle(4);
`ifdef TURN_TIMEOUT_EN
    check("to_pulse", timeout, 1);
    check("to_in1", in1, 2'b00);
    check("to_state", o_state, 2);
`else
    check("no_to_state", o_state, 1);
`endif
    idle(3);

    // Async reset mid-turn with start held high
    step(0, 1, 2'b00, 0, 2'b00, 0);
    step(1, 0, 2'b00, 0, 2'b00, 0);
    step(1, 0, 2'b11, 0, 2'b00, 0);
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) step(1, 0, 2'b00, 0, 2'b00, 0);
    check("rst_hold_busy", busy, 0);
    step(0, 0, 2'b00, 0, 2'b00, 0);
    step(1, 0, 2'b00, 0, 2'b00, 0);
    check("rst_restart", busy, 1);

    // Random play
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end
      step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
